fp_operand_prep: RTL and testbench
==================================

FP_OPERAND_PREP -- requirements
Module: fp_operand_prep

Interface
REQ-001 Parameter: none; IEEE-754 single precision only (8-bit exponent, 23-bit fraction, bias 127).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  stage 1 can accept this cycle.
REQ-006 a, b  input  32 each  packed operands.
REQ-007 opcode  input  1  0 = add, 1 = subtract (a - b).
REQ-008 out_valid  output  1  prepared operand pair present.
REQ-009 out_ready  input  1  downstream adder accepts.
REQ-010 sa, sb  output  1 each  sign of big / small operand; sb already includes opcode inversion.
REQ-011 ea, eb  output  8 each  effective exponent of big / small operand.
REQ-012 ma, mb  output  24 each  significand with hidden bit, big / small operand.
REQ-013 exp_diff  output  8  ea - eb, unsigned.
REQ-014 swap  output  1  1 when b had larger magnitude.
REQ-015 special  output  2  00 normal, 01 zero result path, 10 infinity, 11 NaN.

Function
REQ-016 Two-stage pipeline: S1 unpack and classify, S2 magnitude compare, swap and exp_diff; latency exactly 2 cycles from accepted input to out_valid when unstalled.
REQ-017 Transfer on a port occurs only when valid and ready are both 1 on the same rising edge.
REQ-018 A stage captures when it is empty or its contents leave the same cycle; in_ready = !s1_valid | (s1 advancing into S2).
REQ-019 Under out_ready = 0, both stages fill and hold; held outputs remain stable; no operand is lost or duplicated.
REQ-020 Throughput: one pair per cycle when out_ready stays 1.
REQ-021 Unpack: exponent 0 gives hidden bit 0 and effective exponent 1 (denormal); otherwise hidden bit 1 and the raw exponent.
REQ-022 Effective b sign = b[31] XOR opcode.
REQ-023 Compare on {exponent, fraction}; b strictly greater sets swap = 1; equal magnitudes keep a as big (swap = 0).
REQ-024 special = 11 when either operand is NaN, or when infinities of opposite effective sign meet; 10 for any other infinity; 01 when both operands are zero; else 00.
REQ-025 When special != 00, sa/ea/ma still follow REQ-021..023 and the adder selects on special alone.
REQ-026 Simultaneous input accept and output drain is legal and does not create a bubble.

Reset
REQ-027 Asserting rst_n low clears s1_valid and s2_valid immediately; out_valid = 0, in_ready = 1 after release.
REQ-028 Data registers reset to 0: sa, sb, ea, eb, ma, mb, exp_diff, swap and special all read 0.
REQ-029 Reset mid-operation discards in-flight pairs; no output handshake occurs for them.

Structure
REQ-030 Shared package fp_pkg holds the constants EXP_W = 8, FRAC_W = 23, and BIAS = 127, plus a 2-bit special-class encoding type.
REQ-031 One sub-module, fp_unpack (combinational, one instance per operand), feeds S1.
REQ-032 Estimated size is 150–250 lines of RTL.

Verification
REQ-033 a = 0x40400000 (3.0), b = 0x40A00000 (5.0), op = 0 -> 2 cycles later: swap = 1, ea = 0x81, ma = 0xA00000, eb = 0x80, mb = 0xC00000, exp_diff = 1, sb = 0, special = 00.
REQ-034 a = 0x3F800000, b = 0x3F800000, op = 1 -> swap = 0, exp_diff = 0, sa = 0, sb = 1, ma = mb = 0x800000.
REQ-035 a = 0x00000001 (denormal), b = 0x00000000 -> ea = 1, ma = 0x000001, eb = 1, mb = 0, special = 00; a = b = 0 -> special = 01.
REQ-036 a = 0x7F800000, b = 0x7F800000, op = 1 -> special = 11; a = 0x7FC00000 with any b -> 11; a = 0x7F800000, b = 0x3F800000 -> 10.
REQ-037 Stream 8 pairs back-to-back with out_ready low on cycles 3–5 -> all 8 emerge in order, none dropped or duplicated, and outputs stay stable while stalled.
REQ-038 Drop rst_n for 1 cycle with 2 pairs in flight -> out_valid falls immediately and no stale pair appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: single-precision field widths, bias, special-class encoding and the stage payload type
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;
  typedef struct packed {
    logic              sa;
    logic              sb;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W:0]   ma;
    logic [FRAC_W:0]   mb;
    special_e          special;
  } pair_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational unpack of one operand (x in; sign, effective exponent, significand with hidden bit, zero/inf/nan flags out)
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      x,
  output logic             sign,
  output logic [EXP_W-1:0] exp_eff,
  output logic [FRAC_W:0]  man,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic              hidden;
  always_comb begin
    e = x[30:23];
    f = x[22:0];
    hidden = |e;
    sign = x[31];
    exp_eff = hidden ? e : EXP_W'(1);
    man = {hidden, f};
    is_zero = !hidden && f == '0;
    is_inf = e == EXP_MAX && f == '0;
    is_nan = e == EXP_MAX && f != '0;
  end
endmodule

// File: rtl/fp_operand_prep.sv
// fp_operand_prep: 2-stage add/sub operand prep (in_valid/in_ready/a/b/opcode in; out_valid/out_ready, big/small sign/exp/significand, exp_diff, swap, special out)
module fp_operand_prep
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sa,
  output logic              sb,
  output logic [EXP_W-1:0]  ea,
  output logic [EXP_W-1:0]  eb,
  output logic [FRAC_W:0]   ma,
  output logic [FRAC_W:0]   mb,
  output logic [EXP_W-1:0]  exp_diff,
  output logic              swap,
  output logic [1:0]        special
);
  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [FRAC_W:0]  a_man, b_man;
  logic             b_sign_eff, b_big, s2_en, s2_load;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             swap_q, swap_d;
  logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
  special_e         cls;
  pair_t            pair_new, pair_sw, s1_q, s1_d, s2_q, s2_d;
  fp_unpack u_a (
    .x(a), .sign(a_sign), .exp_eff(a_exp), .man(a_man),
    .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan)
  );
  fp_unpack u_b (
    .x(b), .sign(b_sign), .exp_eff(b_exp), .man(b_man),
    .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan)
  );
  always_comb begin
    b_sign_eff = b_sign ^ opcode;
    cls = (a_nan || b_nan || (a_inf && b_inf && a_sign != b_sign_eff)) ? SP_NAN :
          (a_inf || b_inf) ? SP_INF :
          (a_zero && b_zero) ? SP_ZERO : SP_NORMAL;
    pair_new = '{sa: a_sign, sb: b_sign_eff, ea: a_exp, eb: b_exp, ma: a_man, mb: b_man, special: cls};
    s2_en = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_en;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d = (in_valid && in_ready) ? pair_new : s1_q;
    b_big = {s1_q.eb, s1_q.mb} > {s1_q.ea, s1_q.ma};
    pair_sw = b_big ? '{sa: s1_q.sb, sb: s1_q.sa, ea: s1_q.eb, eb: s1_q.ea, ma: s1_q.mb, mb: s1_q.ma, special: s1_q.special} : s1_q;
    s2_load = s2_en && s1_valid_q;
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    s2_d = s2_load ? pair_sw : s2_q;
    swap_d = s2_load ? b_big : swap_q;
    exp_diff_d = s2_load ? pair_sw.ea - pair_sw.eb : exp_diff_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      swap_q <= 1'b0;
      exp_diff_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      swap_q <= swap_d;
      exp_diff_q <= exp_diff_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign sa = s2_q.sa;
  assign sb = s2_q.sb;
  assign ea = s2_q.ea;
  assign eb = s2_q.eb;
  assign ma = s2_q.ma;
  assign mb = s2_q.mb;
  assign special = s2_q.special;
  assign swap = swap_q;
  assign exp_diff = exp_diff_q;
endmodule

// File: tb/tb_fp_operand_prep.sv
// tb_fp_operand_prep: scoreboard bench for fp_operand_prep with directed vectors, stall and reset scenarios
module tb_fp_operand_prep;
  typedef struct packed {
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [7:0]  diff;
    logic        swap;
    logic [1:0]  sp;
  } res_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        r;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, opcode, out_valid, out_ready;
  logic [31:0] a, b;
  logic        sa, sb, swap;
  logic [7:0]  ea, eb, exp_diff;
  logic [23:0] ma, mb;
  logic [1:0]  special;
  int          compared = 0;
  int          mismatched = 0;
  res_t        sbq[$];
  res_t        held;
  logic        stalled = 1'b0;
  vec_t        vecs[12];
  fp_operand_prep dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .sa(sa), .sb(sb), .ea(ea), .eb(eb), .ma(ma), .mb(mb),
    .exp_diff(exp_diff), .swap(swap), .special(special)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [31:0] va, vb, input logic op, input logic esa, esb,
                              input logic [7:0] eea, eeb, input logic [23:0] ema, emb,
                              input logic [7:0] ed, input logic esw, input logic [1:0] esp);
    return '{a: va, b: vb, op: op,
             r: '{sa: esa, sb: esb, ea: eea, eb: eeb, ma: ema, mb: emb, diff: ed, swap: esw, sp: esp}};
  endfunction
  function automatic res_t cur();
    return '{sa: sa, sb: sb, ea: ea, eb: eb, ma: ma, mb: mb, diff: exp_diff, swap: swap, sp: special};
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic send(input vec_t v);
    int n = 0;
    logic acc;
    a = v.a;
    b = v.b;
    opcode = v.op;
    in_valid = 1'b1;
    do begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (acc) sbq.push_back(v.r);
    else chk("send_timeout", 128'(acc), 128'(1));
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 128'(sbq.size()), 128'(0));
  endtask
  always @(negedge clk) begin
    res_t c;
    res_t e;
    c = cur();
    if (out_valid && !out_ready) begin
      if (stalled) chk("stall_hold", 128'(c), 128'(held));
      held = c;
      stalled = 1'b1;
    end else stalled = 1'b0;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output got=%h", c);
      end else begin
        e = sbq.pop_front();
        chk("result", 128'(c), 128'(e));
      end
    end
  end
  initial begin
    vecs[0]  = mk(32'h40400000, 32'h40A00000, 0, 0, 0, 8'h81, 8'h80, 24'hA00000, 24'hC00000, 8'h01, 1, 2'b00);
    vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1, 0, 1, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 8'h00, 0, 2'b00);
    vecs[2]  = mk(32'h00000001, 32'h00000000, 0, 0, 0, 8'h01, 8'h01, 24'h000001, 24'h000000, 8'h00, 0, 2'b00);
    vecs[3]  = mk(32'h00000000, 32'h00000000, 0, 0, 0, 8'h01, 8'h01, 24'h000000, 24'h000000, 8'h00, 0, 2'b01);
    vecs[4]  = mk(32'h7F800000, 32'h7F800000, 1, 0, 1, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 8'h00, 0, 2'b11);
    vecs[5]  = mk(32'h7FC00000, 32'h3F800000, 0, 0, 0, 8'hFF, 8'h7F, 24'hC00000, 24'h800000, 8'h80, 0, 2'b11);
    vecs[6]  = mk(32'h7F800000, 32'h3F800000, 0, 0, 0, 8'hFF, 8'h7F, 24'h800000, 24'h800000, 8'h80, 0, 2'b10);
    vecs[7]  = mk(32'hC0000000, 32'h40800000, 1, 1, 1, 8'h81, 8'h80, 24'h800000, 24'h800000, 8'h01, 1, 2'b00);
    vecs[8]  = mk(32'h7F800000, 32'h7F800000, 0, 0, 0, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 8'h00, 0, 2'b10);
    vecs[9]  = mk(32'h00000000, 32'h80000000, 0, 0, 1, 8'h01, 8'h01, 24'h000000, 24'h000000, 8'h00, 0, 2'b01);
    vecs[10] = mk(32'h3F800000, 32'h3FC00000, 0, 0, 0, 8'h7F, 8'h7F, 24'hC00000, 24'h800000, 8'h00, 1, 2'b00);
    vecs[11] = mk(32'h00800000, 32'h007FFFFF, 0, 0, 0, 8'h01, 8'h01, 24'h800000, 24'h7FFFFF, 8'h00, 0, 2'b00);
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    opcode = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid_rel", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(cur()), 128'(0));
    send(vecs[0]);
    chk("latency_c1", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    chk("latency_c2", 128'(out_valid), 128'(1));
    drain();
    for (int i = 0; i < 12; i++) send(vecs[i]);
    drain();
    fork
      for (int i = 0; i < 8; i++) send(vecs[i]);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", 128'(out_valid), 128'(0));
    send(vecs[2]);
    drain();
    chk("queue_empty", 128'(sbq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
